// File: rtl/rggen_host_if_apb_bridge.sv
// rggen_host_if_apb_bridge: registered APB slave to rggen register-bus bridge with range decode and timeout
module rggen_host_if_apb_bridge #(
    parameter int                       ADDRESS_WIDTH       = 32,
    parameter int                       LOCAL_ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH          = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                       TIMEOUT_CYCLES      = 0
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
    input  logic                           i_pwrite,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
    output logic                           o_pready,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pslverr,
    output logic                           o_bus_request,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_bus_address,
    output logic                           o_bus_direction,
    output logic [DATA_WIDTH-1:0]          o_bus_write_data,
    output logic [DATA_WIDTH/8-1:0]        o_bus_write_strobe,
    input  logic                           i_bus_done,
    input  logic [DATA_WIDTH-1:0]          i_bus_read_data,
    input  logic [1:0]                     i_bus_status
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0]       HI_MASK    = {ADDRESS_WIDTH{1'b1}} << LOCAL_ADDRESS_WIDTH;
    localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ALIGN_MASK = {LOCAL_ADDRESS_WIDTH{1'b1}} << LSB;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                         state;
    logic [31:0]                    count;
    logic [LOCAL_ADDRESS_WIDTH-1:0] addr;
    logic                           dir;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [STRB_WIDTH-1:0]          strb;
    logic                           in_range;
    logic                           timeout;
    logic                           unused_status;

    assign in_range      = ((i_paddr ^ BASE_ADDRESS) & HI_MASK) == '0;
    assign timeout       = (TIMEOUT_CYCLES != 0) && (count == 32'(TIMEOUT_CYCLES - 1));
    assign unused_status = i_bus_status[0];

    assign o_bus_request      = state == BUSY;
    assign o_bus_address      = addr;
    assign o_bus_direction    = dir;
    assign o_bus_write_data   = wdata;
    assign o_bus_write_strobe = strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            addr      <= '0;
            dir       <= 1'b0;
            wdata     <= '0;
            strb      <= '0;
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_pready  <= 1'b0;
                    o_prdata  <= '0;
                    o_pslverr <= 1'b0;
                    if (i_psel && !i_penable) begin
                        addr  <= i_paddr[LOCAL_ADDRESS_WIDTH-1:0] & ALIGN_MASK;
                        dir   <= i_pwrite;
                        wdata <= i_pwdata;
                        strb  <= i_pwrite ? i_pstrb : '0;
                        count <= '0;
                        // out-of-window accesses answer with an error without touching the bus
                        state     <= in_range ? BUSY : RESP;
                        o_pready  <= !in_range;
                        o_pslverr <= !in_range;
                    end
                end
                BUSY: begin
                    if (i_bus_done) begin
                        state     <= RESP;
                        o_pready  <= 1'b1;
                        o_prdata  <= dir ? '0 : i_bus_read_data;
                        o_pslverr <= i_bus_status[1];
                    end else if (timeout) begin
                        state     <= RESP;
                        o_pready  <= 1'b1;
                        o_prdata  <= '0;
                        o_pslverr <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_pready  <= 1'b0;
                    o_prdata  <= '0;
                    o_pslverr <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_host_if_apb_bridge.sv
// tb_rggen_host_if_apb_bridge: directed scoreboard bench for the APB to rggen bus bridge
module tb_rggen_host_if_apb_bridge;
  logic        clk = 0;
  logic        rst;
  logic        i_psel, i_penable, i_pwrite;
  logic [31:0] i_paddr, i_pwdata;
  logic [3:0]  i_pstrb;
  logic        o_pready, o_pslverr;
  logic [31:0] o_prdata;
  logic        o_bus_request, o_bus_direction;
  logic [15:0] o_bus_address;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_write_strobe;
  logic        i_bus_done;
  logic [31:0] i_bus_read_data;
  logic [1:0]  i_bus_status;
  int          checks = 0;
  int          failures = 0;
  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          lat;
    int          reqs;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  rggen_host_if_apb_bridge #(
    .ADDRESS_WIDTH(32), .LOCAL_ADDRESS_WIDTH(16), .DATA_WIDTH(32),
    .BASE_ADDRESS(32'h0001_0000), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_psel(i_psel), .i_penable(i_penable), .i_paddr(i_paddr), .i_pwrite(i_pwrite),
    .i_pwdata(i_pwdata), .i_pstrb(i_pstrb),
    .o_pready(o_pready), .o_prdata(o_prdata), .o_pslverr(o_pslverr),
    .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
    .o_bus_direction(o_bus_direction), .o_bus_write_data(o_bus_write_data),
    .o_bus_write_strobe(o_bus_write_strobe),
    .i_bus_done(i_bus_done), .i_bus_read_data(i_bus_read_data), .i_bus_status(i_bus_status)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ex);
    checks++;
    if (obs !== ex) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                      input int done_at, input logic [31:0] rd, input logic [1:0] bs,
                      input int lat, input int reqs_exp, input logic [31:0] prd_exp, input logic err_exp);
    int   reqs = 0;
    bit   got = 0;
    exp_t e;
    sb.push_back('{prd_exp, err_exp, lat, reqs_exp});
    i_psel = 1; i_penable = 0; i_paddr = a; i_pwrite = w; i_pwdata = wd; i_pstrb = st;
    step();
    i_penable = 1;
    for (int c = 1; c <= 20; c++) begin
      i_bus_done = 0;
      if (o_bus_request) begin
        reqs++;
        if (reqs == 1) begin
          chk("bus_address", o_bus_address, a[15:0] & 16'hFFFC);
          chk("bus_direction", o_bus_direction, w);
          chk("bus_write_data", o_bus_write_data, wd);
          chk("bus_write_strobe", o_bus_write_strobe, w ? st : 4'h0);
        end
        i_bus_done = (reqs == done_at);
        i_bus_read_data = rd;
        i_bus_status = bs;
      end
      if (o_pready) begin
        got = 1;
        e = sb.pop_front();
        chk("prdata", o_prdata, e.prdata);
        chk("pslverr", o_pslverr, e.err);
        chk("pready_latency", c, e.lat);
        chk("request_cycles", reqs, e.reqs);
        break;
      end
      step();
    end
    chk("pready_seen", got, 1'b1);
    i_psel = 0; i_penable = 0; i_bus_done = 0;
    step();
    chk("pready_one_cycle", o_pready, 1'b0);
    chk("prdata_cleared", o_prdata, 32'h0);
    chk("pslverr_cleared", o_pslverr, 1'b0);
  endtask
  initial begin
    rst = 1; i_psel = 0; i_penable = 0; i_paddr = 0; i_pwrite = 0; i_pwdata = 0; i_pstrb = 0;
    i_bus_done = 0; i_bus_read_data = 0; i_bus_status = 0;
    step(); step();
    rst = 0;
    chk("reset_pready", o_pready, 1'b0);
    chk("reset_prdata", o_prdata, 32'h0);
    chk("reset_pslverr", o_pslverr, 1'b0);
    chk("reset_request", o_bus_request, 1'b0);
    chk("reset_address", o_bus_address, 16'h0);
    chk("reset_strobe", o_bus_write_strobe, 4'h0);
    xfer(32'h0001_0104, 1, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_5555, 2'b00, 2, 1, 32'h0, 0);
    xfer(32'h0001_0008, 0, 32'h0, 4'h0, 3, 32'h1234_5678, 2'b00, 4, 3, 32'h1234_5678, 0);
    xfer(32'h0002_0000, 0, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 2'b00, 1, 0, 32'h0, 1);
    xfer(32'h0001_0010, 1, 32'hCAFE_0001, 4'h3, 2, 32'h0, 2'b10, 3, 2, 32'h0, 1);
    xfer(32'h0001_0014, 0, 32'h0, 4'h0, 1, 32'h0000_A5A5, 2'b11, 2, 1, 32'h0000_A5A5, 1);
    xfer(32'h0001_0018, 0, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 2'b01, 2, 1, 32'h0BAD_F00D, 0);
    xfer(32'h0001_001C, 0, 32'h0, 4'h0, 0, 32'h7777_7777, 2'b00, 5, 4, 32'h0, 1);
    xfer(32'h0001_0020, 0, 32'h0, 4'h0, 4, 32'h8888_8888, 2'b00, 5, 4, 32'h8888_8888, 0);
    xfer(32'h0001_0003, 0, 32'h0, 4'hF, 1, 32'h0000_0042, 2'b00, 2, 1, 32'h0000_0042, 0);
    i_psel = 1; i_penable = 1; i_paddr = 32'h0001_0040; i_bus_done = 1;
    step(); step();
    chk("no_setup_request", o_bus_request, 1'b0);
    chk("no_setup_pready", o_pready, 1'b0);
    i_psel = 0; i_penable = 0; i_bus_done = 0;
    step();
    i_psel = 1; i_penable = 0; i_paddr = 32'h0001_0030; i_pwrite = 1; i_pwdata = 32'h1; i_pstrb = 4'h1;
    step();
    i_penable = 1;
    chk("busy_request", o_bus_request, 1'b1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_busy_request", o_bus_request, 1'b0);
    chk("rst_busy_pready", o_pready, 1'b0);
    i_psel = 0; i_penable = 0;
    step();
    chk("rst_idle_request", o_bus_request, 1'b0);
    xfer(32'h0001_0034, 0, 32'h0, 4'h0, 2, 32'h600D_0001, 2'b00, 3, 2, 32'h600D_0001, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
